// File: rtl/max2769_pkg.sv
// Shared types and constants for the MAX2769 configuration sequencer.
package max2769_pkg;

  localparam int FRAME_BITS   = 32;
  localparam int DATA_BITS    = 28;
  localparam int NUM_DEFAULTS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_WAIT_LOCK,
    ST_STREAM
  } cfg_state_t;

  localparam logic [DATA_BITS-1:0] MAX2769_DEFAULTS [NUM_DEFAULTS] = '{
    28'hA2919A3, 28'h0550288, 28'hEAFF1DC, 28'h9EC0008, 28'h0C00080,
    28'h8000070, 28'h8000000, 28'h10061B2, 28'h1E0F401, 28'h14C0402
  };

  // Registers beyond the datasheet table power up as zero.
  function automatic logic [DATA_BITS-1:0] default_reg(input int i);
    return (i < NUM_DEFAULTS) ? MAX2769_DEFAULTS[i] : '0;
  endfunction

endpackage

// File: rtl/max2769_spi_tx.sv
// 3-wire frame transmitter: shifts one 32-bit frame MSB first with CS framing.
module max2769_spi_tx
  import max2769_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  sclk,
  output logic                  sdata,
  output logic                  cs_n,
  output logic                  done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic                  active;
  logic [DIV_W-1:0]      div_cnt;
  logic [4:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;

  // High during the final cycle of bit 0; CS rises on the following edge.
  assign done = active & sclk & (div_cnt == DIV_LAST) & (bit_cnt == 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (load) begin
      active  <= 1'b1;
      cs_n    <= 1'b0;
      sclk    <= 1'b0;
      sdata   <= frame[FRAME_BITS-1];
      div_cnt <= '0;
      bit_cnt <= 5'(FRAME_BITS - 1);
      shreg   <= frame;
    end else if (active) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else if (bit_cnt == 5'd0) begin
          active <= 1'b0;
          cs_n   <= 1'b1;
          sclk   <= 1'b0;
          sdata  <= 1'b0;
        end else begin
          // Data only moves on the falling edge so the device samples on the rise.
          sclk    <= 1'b0;
          shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
          sdata   <= shreg[FRAME_BITS-2];
          bit_cnt <= bit_cnt - 5'd1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/max2769_config.sv
// MAX2769 configuration sequencer: shadow registers, programming FSM, lock
// supervision and the sample-bridge stream enable.
module max2769_config
  import max2769_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int NUM_REGS     = 10,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                 MCU_CLK,
  input  logic                 RESET,
  input  logic                 WR_VALID,
  input  logic [3:0]           WR_ADDR,
  input  logic [DATA_BITS-1:0] WR_DATA,
  output logic                 WR_READY,
  input  logic                 GO,
  input  logic                 MAX_LD,
  output logic                 MAX_SCLK,
  output logic                 MAX_SDATA,
  output logic                 MAX_CS_N,
  output logic                 STREAM_EN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 LOCK_FAIL
);

  localparam int CNT_MAX = (LOCK_TIMEOUT > 2 * CLK_DIV) ? LOCK_TIMEOUT : 2 * CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       LAST_IDX = 4'(NUM_REGS - 1);
  localparam logic [4:0]       NREGS    = 5'(NUM_REGS);

  cfg_state_t           state, state_d;
  logic [3:0]           idx, idx_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 lock_fail_d;
  logic                 load;
  logic                 tx_done;
  logic                 ld_p0, ld_p1;
  logic                 wr_ok;
  logic [DATA_BITS-1:0] shadow [NUM_REGS];

  assign WR_READY  = (state == ST_IDLE) | (state == ST_STREAM);
  assign BUSY      = (state == ST_LOAD) | (state == ST_SHIFT) |
                     (state == ST_GAP)  | (state == ST_WAIT_LOCK);
  assign STREAM_EN = (state == ST_STREAM);
  assign DONE      = (state == ST_STREAM);
  assign wr_ok     = WR_VALID & WR_READY & ({1'b0, WR_ADDR} < NREGS);

  // LD synchroniser: two flops before the FSM sees lock detect.
  always_ff @(posedge MCU_CLK) begin
    if (RESET) begin
      ld_p0 <= 1'b0;
      ld_p1 <= 1'b0;
    end else begin
      ld_p0 <= MAX_LD;
      ld_p1 <= ld_p0;
    end
  end

  always_ff @(posedge MCU_CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= default_reg(i);
    end else if (wr_ok) begin
      shadow[WR_ADDR] <= WR_DATA;
    end
  end

  always_ff @(posedge MCU_CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cnt       <= '0;
      LOCK_FAIL <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      cnt       <= cnt_d;
      LOCK_FAIL <= lock_fail_d;
    end
  end

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    cnt_d       = cnt + 1'b1;
    lock_fail_d = LOCK_FAIL;
    load        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (GO) begin
          state_d     = ST_LOAD;
          idx_d       = '0;
          lock_fail_d = 1'b0;
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tx_done) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          if (idx == LAST_IDX) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            state_d = ST_LOAD;
            idx_d   = idx + 4'd1;
          end
        end
      end
      ST_WAIT_LOCK: begin
        if (ld_p1) begin
          state_d = ST_STREAM;
        end else if (cnt == TO_LAST) begin
          state_d     = ST_IDLE;
          lock_fail_d = 1'b1;
        end
      end
      ST_STREAM: begin
        // Losing lock takes priority over a simultaneous reprogram request.
        if (!ld_p1) begin
          state_d     = ST_IDLE;
          lock_fail_d = 1'b1;
        end else if (GO) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  max2769_spi_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_spi_tx (
    .clk   (MCU_CLK),
    .rst   (RESET),
    .load  (load),
    .frame ({shadow[idx], idx}),
    .sclk  (MAX_SCLK),
    .sdata (MAX_SDATA),
    .cs_n  (MAX_CS_N),
    .done  (tx_done)
  );

endmodule
